// File: rtl/io_map_pkg.sv
// Shared address map, status bit layout and PS/2 receiver state encoding.
// No logic; constants and types only.
// Imported by the keyboard bridge and its PS/2 receiver.
package io_map_pkg;

  // Default value of m_addr[31:28] that routes an access to the I/O region
  localparam logic [3:0] IO_NIBBLE_DEF = 4'hA;

  // Byte offsets of the keyboard registers inside the I/O region
  localparam logic [3:0] KBD_DATA   = 4'h0;
  localparam logic [3:0] KBD_STATUS = 4'h4;

  // Bit positions inside the STATUS word
  localparam int ST_NE      = 0;
  localparam int ST_OVF     = 1;
  localparam int ST_PERR    = 2;
  localparam int ST_CNT_LSB = 8;

  // PS/2 receiver frame states
  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_t;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronise, de-glitch the PS/2 clock, deserialise 11-bit frames.
// Code is presented in the cycle the stop-bit falling edge is registered (single-cycle pulse).
// No backpressure: the consumer must accept code_valid_o when it pulses.
module ps2_rx
  import io_map_pkg::*;
#(
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] code_o,
  output logic       code_valid_o,
  output logic       perr_pulse_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]  clk_sync_q;
  logic [1:0]  dat_sync_q;
  logic [3:0]  hist_q;
  logic        filt_q;
  logic        filt_d;
  logic        fall_q;
  rx_state_t   state_q;
  logic [2:0]  bitcnt_q;
  logic [7:0]  shift_q;
  logic        par_q;
  logic [TW-1:0] tmo_q;
  logic        tmo_hit;
  logic        frame_ok;
  logic        stop_fall;

  // Filtered PS/2 clock only changes after four agreeing samples
  always_comb begin
    filt_d = filt_q;
    if (hist_q == 4'h0) begin
      filt_d = 1'b0;
    end else if (hist_q == 4'hF) begin
      filt_d = 1'b1;
    end
  end

  // Two-flop synchronisers, clock history filter and registered falling-edge strobe
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      hist_q     <= 4'hF;
      filt_q     <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_data_i};
      hist_q     <= {hist_q[2:0], clk_sync_q[1]};
      filt_q     <= filt_d;
      fall_q     <= filt_q & ~filt_d;
    end
  end

  assign tmo_hit = (tmo_q == TW'(TIMEOUT));

  // Idle-time counter: cleared by every falling edge, saturates at TIMEOUT
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      tmo_q <= '0;
    end else if (fall_q) begin
      tmo_q <= '0;
    end else if (!tmo_hit) begin
      tmo_q <= tmo_q + TW'(1);
    end
  end

  // Frame FSM: one step per filtered falling edge, abandon partial frames on timeout
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= RX_IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
    end else if (fall_q) begin
      case (state_q)
        RX_IDLE: begin
          if (!dat_sync_q[1]) begin
            state_q  <= RX_DATA;
            bitcnt_q <= '0;
          end
        end
        RX_DATA: begin
          shift_q  <= {dat_sync_q[1], shift_q[7:1]};
          bitcnt_q <= bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_q <= RX_PARITY;
          end
        end
        RX_PARITY: begin
          par_q   <= dat_sync_q[1];
          state_q <= RX_STOP;
        end
        default: begin
          state_q <= RX_IDLE;
        end
      endcase
    end else if (tmo_hit && (state_q != RX_IDLE)) begin
      state_q <= RX_IDLE;
    end
  end

  // Stop bit must be 1 and data+parity must carry odd parity
  assign stop_fall    = fall_q && (state_q == RX_STOP);
  assign frame_ok     = dat_sync_q[1] && (^{shift_q, par_q});
  assign code_valid_o = stop_fall && frame_ok;
  assign perr_pulse_o = stop_fall && !frame_ok;
  assign code_o       = shift_q;

endmodule

// File: rtl/kbd_io_bridge.sv
// CPU data-port decoder: data RAM vs keyboard DATA/STATUS registers, plus scan-code FIFO.
// Read data is combinational (same cycle); pops and W1C clears take effect at the cycle end.
// No backpressure: a code arriving while the FIFO is full is dropped and flagged as overflow.
module kbd_io_bridge
  import io_map_pkg::*;
#(
  parameter int         FIFO_DEPTH = 8,
  parameter int         FIFO_AW    = 3,
  parameter int         TIMEOUT    = 50000,
  parameter logic [3:0] IO_NIBBLE  = IO_NIBBLE_DEF
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] m_addr,
  input  logic        m_write,
  input  logic        m_read,
  input  logic [31:0] d_t_mem,
  output logic [31:0] d_f_mem,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_we,
  input  logic        ps2_clk,
  input  logic        ps2_data
);

  logic [7:0]       rx_code;
  logic             rx_valid;
  logic             rx_perr;
  logic             io_sel;
  logic             is_data;
  logic             is_stat;
  logic             pop;
  logic             push_ok;
  logic             ovf_set;
  logic             nonempty;
  logic             full;
  logic             clr_ovf;
  logic             clr_perr;
  logic [31:0]      status;
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic             ovf_q;
  logic             perr_q;
  logic             unused_ok;

  ps2_rx #(.TIMEOUT(TIMEOUT)) u_rx (
    .clk          (clk),
    .clrn         (clrn),
    .ps2_clk_i    (ps2_clk),
    .ps2_data_i   (ps2_data),
    .code_o       (rx_code),
    .code_valid_o (rx_valid),
    .perr_pulse_o (rx_perr)
  );

  assign io_sel  = (m_addr[31:28] == IO_NIBBLE);
  assign is_data = (m_addr[3:2] == KBD_DATA[3:2]);
  assign is_stat = (m_addr[3:2] == KBD_STATUS[3:2]);
  assign dmem_we = m_write & ~io_sel;

  assign nonempty = (count_q != '0);
  assign full     = (count_q == (FIFO_AW + 1)'(FIFO_DEPTH));
  assign pop      = m_read & io_sel & is_data & nonempty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  assign push_ok  = rx_valid & (~full | pop);
  assign ovf_set  = rx_valid & full & ~pop;
  assign clr_ovf  = m_write & io_sel & is_stat & d_t_mem[ST_OVF];
  assign clr_perr = m_write & io_sel & is_stat & d_t_mem[ST_PERR];

  assign unused_ok = ^{m_addr[27:4], m_addr[1:0], d_t_mem[31:3], d_t_mem[0]};

  // Assemble the STATUS word
  always_comb begin
    status                     = '0;
    status[ST_NE]              = nonempty;
    status[ST_OVF]             = ovf_q;
    status[ST_PERR]            = perr_q;
    status[ST_CNT_LSB +: 4]    = 4'(count_q);
  end

  // Same-cycle read mux: RAM outside the I/O region, keyboard registers inside
  always_comb begin
    d_f_mem = dmem_rdata;
    if (io_sel) begin
      d_f_mem = '0;
      if (is_data && nonempty) begin
        d_f_mem = {24'h0, fifo_mem[rd_ptr_q]};
      end else if (is_stat) begin
        d_f_mem = status;
      end
    end
  end

  // FIFO storage needs no reset: entries are only visible behind a nonzero count
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q] <= rx_code;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      count_q <= count_q + (FIFO_AW + 1)'(push_ok) - (FIFO_AW + 1)'(pop);
    end
  end

  // Sticky error flags, write-1-to-clear, a same-cycle set beats the clear
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ovf_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_set | (ovf_q & ~clr_ovf);
      perr_q <= rx_perr | (perr_q & ~clr_perr);
    end
  end

endmodule

// File: tb/tb_kbd_io_bridge.sv
// Scoreboard bench for kbd_io_bridge: directed CPU accesses and PS/2 frames.
// Expected responses are queued at issue time and checked by an independent monitor.
// Monitor samples on the falling clock edge, mid-way through each access cycle.
module tb_kbd_io_bridge;

  localparam int TIMEOUT = 50000;
  localparam int HALF    = 10;

  logic        clk = 1'b0;
  logic        clrn;
  logic [31:0] m_addr;
  logic        m_write;
  logic        m_read;
  logic [31:0] d_t_mem;
  logic [31:0] d_f_mem;
  logic [31:0] dmem_rdata;
  logic        dmem_we;
  logic        ps2_clk;
  logic        ps2_data;

  typedef struct {
    string       name;
    logic [31:0] exp;
    bit          is_we;
  } exp_t;

  exp_t sb_q[$];
  bit   chk_vld = 1'b0;
  bit   done    = 1'b0;
  int   errors  = 0;
  int   checks  = 0;

  kbd_io_bridge #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .m_addr     (m_addr),
    .m_write    (m_write),
    .m_read     (m_read),
    .d_t_mem    (d_t_mem),
    .d_f_mem    (d_f_mem),
    .dmem_rdata (dmem_rdata),
    .dmem_we    (dmem_we),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data)
  );

  always #5 clk = ~clk;

  // One CPU access cycle; the expected response is queued for the monitor
  task automatic cpu_access(input logic [31:0] a, input bit rd, input bit wr,
                            input logic [31:0] wd, input logic [31:0] exp,
                            input bit chk_we, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    m_addr  = a;
    m_read  = rd;
    m_write = wr;
    d_t_mem = wd;
    e.name  = nm;
    e.exp   = exp;
    e.is_we = chk_we;
    sb_q.push_back(e);
    chk_vld = 1'b1;
    @(posedge clk);
    #1;
    m_read  = 1'b0;
    m_write = 1'b0;
    chk_vld = 1'b0;
    m_addr  = 32'h0000_0000;
    d_t_mem = 32'h0;
  endtask

  task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string nm);
    cpu_access(a, 1'b1, 1'b0, 32'h0, exp, 1'b0, nm);
  endtask

  // Store; checks the RAM write strobe for that cycle
  task automatic wr_chk(input logic [31:0] a, input logic [31:0] wd, input bit exp_we,
                        input string nm);
    cpu_access(a, 1'b0, 1'b1, wd, {31'h0, exp_we}, 1'b1, nm);
  endtask

  // One PS/2 bit: data set while the clock is high, then a low and a high phase
  task automatic ps2_bit(input bit b);
    ps2_data = b;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  // Full 11-bit frame; bad_par flips the odd-parity bit
  task automatic send_frame(input logic [7:0] c, input bit bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(c[i]);
    ps2_bit((~^c) ^ bad_par);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (HALF) @(posedge clk);
  endtask

  // Start bit plus the first n data bits, then the line goes quiet
  task automatic send_partial(input logic [7:0] c, input int n);
    ps2_bit(1'b0);
    for (int i = 0; i < n; i++) ps2_bit(c[i]);
    ps2_data = 1'b1;
  endtask

  // Monitor: compares every presented response against the scoreboard head
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    if (chk_vld) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: response with no expected value queued");
      end else begin
        e   = sb_q.pop_front();
        act = e.is_we ? {31'h0, dmem_we} : d_f_mem;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.exp);
        end
      end
    end else if (done) begin
      checks++;
      if (sb_q.size() != 0) begin
        errors++;
        $display("FAIL sb_drain: %0d responses outstanding, expected 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    clrn       = 1'b0;
    m_addr     = 32'h0;
    m_write    = 1'b0;
    m_read     = 1'b0;
    d_t_mem    = 32'h0;
    dmem_rdata = 32'h0;
    ps2_clk    = 1'b1;
    ps2_data   = 1'b1;
    repeat (4) @(posedge clk);
    #1 clrn = 1'b1;
    repeat (2) @(posedge clk);

    // Reset state and empty-FIFO pop
    rd_chk(32'hA000_0004, 32'h0000_0000, "rst_status");
    rd_chk(32'hA000_0000, 32'h0000_0000, "empty_data");
    rd_chk(32'hA000_0004, 32'h0000_0000, "empty_pop_nochg");

    // Single good frame
    send_frame(8'h1C, 1'b0);
    rd_chk(32'hA000_0004, 32'h0000_0101, "one_status");
    rd_chk(32'hA000_0000, 32'h0000_001C, "one_data");
    rd_chk(32'hA000_0004, 32'h0000_0000, "one_drained");

    // Nine frames into an eight-entry FIFO
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0);
    rd_chk(32'hA000_0004, 32'h0000_0803, "full_status");
    for (int i = 1; i <= 8; i++) rd_chk(32'hA000_0000, 32'(i), $sformatf("drain_%0d", i));
    rd_chk(32'hA000_0000, 32'h0000_0000, "drain_empty");
    rd_chk(32'hA000_0004, 32'h0000_0002, "ovf_sticky");
    wr_chk(32'hA000_0004, 32'h0000_0002, 1'b0, "ovf_clr_we");
    rd_chk(32'hA000_0004, 32'h0000_0000, "ovf_cleared");

    // Parity error
    send_frame(8'h5A, 1'b1);
    rd_chk(32'hA000_0004, 32'h0000_0004, "perr_status");
    wr_chk(32'hA000_0004, 32'h0000_0004, 1'b0, "perr_clr_we");
    rd_chk(32'hA000_0004, 32'h0000_0000, "perr_cleared");

    // Partial frame abandoned by timeout, then a clean frame
    send_partial(8'hF5, 4);
    repeat (TIMEOUT + 1) @(posedge clk);
    rd_chk(32'hA000_0004, 32'h0000_0000, "tmo_no_flags");
    send_frame(8'h29, 1'b0);
    rd_chk(32'hA000_0004, 32'h0000_0101, "tmo_status");
    rd_chk(32'hA000_0000, 32'h0000_0029, "tmo_data");
    rd_chk(32'hA000_0004, 32'h0000_0000, "tmo_drained");

    // RAM decode and ignored I/O writes
    wr_chk(32'h0000_0010, 32'h1234_5678, 1'b1, "ram_we");
    wr_chk(32'hA000_0000, 32'h0000_00FF, 1'b0, "io_data_we");
    wr_chk(32'hA000_0008, 32'h0000_0006, 1'b0, "io_unmap_we");
    rd_chk(32'hA000_0004, 32'h0000_0000, "io_write_nochg");
    dmem_rdata = 32'hDEAD_BEEF;
    rd_chk(32'h0000_0010, 32'hDEAD_BEEF, "ram_read");
    rd_chk(32'hA000_0008, 32'h0000_0000, "unmap_read");

    @(posedge clk);
    #1 done = 1'b1;
  end

endmodule

// File: doc/kbd_io_bridge.md
Name: kbd_io_bridge

Overview:
- Memory-mapped I/O bridge between the single-cycle CPU's data-memory port and the data RAM plus a PS/2 keyboard.
- Decodes each CPU data access to RAM or to keyboard registers and returns read data combinationally, in the same cycle.
- Deserialises PS/2 frames into a scan-code FIFO; the CPU polls status and pops codes with lw/lb/lbu.

Parameters:
- FIFO_DEPTH, 8, scan-code FIFO entries; must be a power of 2.
- FIFO_AW, 3, log2(FIFO_DEPTH).
- TIMEOUT, 50000, clk cycles without a PS/2 falling edge before a partial frame is discarded.
- IO_NIBBLE, 4'hA, value of m_addr[31:28] that selects the I/O region.

Ports:
- clk  in  1  system clock
- clrn  in  1  asynchronous active-low reset
- m_addr  in  32  CPU data address
- m_write  in  1  CPU store strobe
- m_read  in  1  CPU load strobe
- d_t_mem  in  32  CPU store data
- d_f_mem  out  32  load data returned to the CPU
- dmem_rdata  in  32  data RAM read data
- dmem_we  out  1  data RAM write enable
- ps2_clk  in  1  raw PS/2 clock (asynchronous)
- ps2_data  in  1  raw PS/2 data (asynchronous)

Behaviour:
- Reset: clrn is asynchronous, active-low; clock is clk. Reset clears FIFO pointers and count, ovf, perr, receiver state, bit counter, timeout counter, and synchroniser and filter state (filter value = 1).
- Decode:
  - io_sel = (m_addr[31:28] == IO_NIBBLE).
  - dmem_we = m_write & ~io_sel, combinational.
  - When io_sel = 0, d_f_mem = dmem_rdata.
  - When io_sel = 1, m_addr[3:2] selects: 0 = DATA, 1 = STATUS, others read 0.
- DATA read: d_f_mem = {24'h0, fifo head}, or 0 when the FIFO is empty. If m_read & io_sel & m_addr[3:2] == 0 and the FIFO is non-empty, pop at the end of the cycle.
- STATUS read: d_f_mem = {20'h0, count[3:0], 5'h0, perr, ovf, nonempty}. count saturates at the FIFO_DEPTH value.
- STATUS write: write-1-to-clear. d_t_mem[1] clears ovf; d_t_mem[2] clears perr. If a set and a clear hit the same cycle, set wins.
- Writes to DATA and to unmapped I/O addresses are ignored.
- PS/2 input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
  - ps2_clk then feeds a 4-bit history filter: filtered goes 0 on 4 consecutive 0s and 1 on 4 consecutive 1s, otherwise holds.
  - fall = filt_q & ~filt, registered.
  - Data is sampled on fall.
- Receiver FSM (one state change per fall):
  - IDLE: sampled 0 -> DATA with bitcnt = 0; sampled 1 -> stay IDLE.
  - DATA: shift bits in LSB first; after 8 bits -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP:
    - stop = 1 and odd parity over data+parity -> push scan code.
    - parity bad or stop = 0 -> no push, set perr.
    - Either case -> IDLE.
- Timeout: the timeout counter resets on every fall. If it reaches TIMEOUT while not in IDLE, return to IDLE, discard the partial frame, and leave flags unchanged.
- Push latency: a push occurs on the clk edge ending the cycle in which the stop-bit fall is registered; nonempty reads 1 from the next cycle.
- Full: a push while full drops the code and sets ovf.
- Push and pop in the same cycle: both occur and count is unchanged. When full, push+pop is legal and no ovf is raised.
- Pop when empty: no state change; read returns 0.
- Pointers wrap modulo FIFO_DEPTH.
- Reset mid-frame or mid-access discards everything; the FIFO restarts empty.

Decomposition:
- Package io_map_pkg:
  - IO_NIBBLE default.
  - Register offsets KBD_DATA = 0, KBD_STATUS = 4.
  - Status bit indices ST_NE = 0, ST_OVF = 1, ST_PERR = 2, ST_CNT_LSB = 8.
  - Receiver state encoding.
- Sub-module ps2_rx: synchroniser, filter, FSM and timeout. Outputs code[7:0], code_valid pulse and perr_pulse.
- Top level holds the decode, FIFO and flags.

Test Plan:
- Reset, then read 0xA0000004 -> 0x00000000. Read 0xA0000000 -> 0x00000000, FIFO unchanged.
- Send PS/2 frame 0x1C with correct odd parity (bit = 0). One cycle after the stop fall, STATUS = 0x00000101. lw 0xA0000000 -> 0x0000001C; next STATUS = 0x00000000.
- Send 9 valid frames 0x01..0x09 with no reads -> STATUS = 0x00000803. Drain -> 0x01..0x08 in order, 0x09 dropped. Write 0x2 to STATUS -> ovf clears.
- Frame 0x5A with wrong parity -> no push, STATUS = 0x00000004. Write 0x4 -> 0x00000000.
- Stop after 4 data bits, wait TIMEOUT+1 cycles, then send a valid 0x29 -> only 0x29 queued, perr = 0.
- sw to 0x00000010 -> dmem_we = 1. sw to 0xA0000000 -> dmem_we = 0, no state change. lw 0x00000010 with dmem_rdata = 0xDEADBEEF -> d_f_mem = 0xDEADBEEF.
